// File: rtl/cotm32_priv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cotm32_priv_pkg                                                   |
// | M-mode privilege types: exception bits, cause codes, trap FSM.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package cotm32_priv_pkg;

  localparam int XLEN    = 32;
  localparam int MXLEN   = 32;
  localparam int CAUSE_W = 5;

  typedef logic [CAUSE_W-1:0] trap_cause_t;

  // Bit positions in the commit-stage exception vector, highest priority first
  typedef enum logic [3:0] {
    EXC_INST_ACCESS    = 4'd0,
    EXC_ILLEGAL        = 4'd1,
    EXC_INST_MISALIGN  = 4'd2,
    EXC_ECALL_M        = 4'd3,
    EXC_EBREAK         = 4'd4,
    EXC_LOAD_ACCESS    = 4'd5,
    EXC_STORE_ACCESS   = 4'd6,
    EXC_LOAD_MISALIGN  = 4'd7,
    EXC_STORE_MISALIGN = 4'd8
  } exc_bit_e;

  localparam int EXC_W = 9;

  localparam trap_cause_t CAUSE_INST_MISALIGN  = 5'd0;
  localparam trap_cause_t CAUSE_INST_ACCESS    = 5'd1;
  localparam trap_cause_t CAUSE_ILLEGAL        = 5'd2;
  localparam trap_cause_t CAUSE_BREAKPOINT     = 5'd3;
  localparam trap_cause_t CAUSE_LOAD_MISALIGN  = 5'd4;
  localparam trap_cause_t CAUSE_LOAD_ACCESS    = 5'd5;
  localparam trap_cause_t CAUSE_STORE_MISALIGN = 5'd6;
  localparam trap_cause_t CAUSE_STORE_ACCESS   = 5'd7;
  localparam trap_cause_t CAUSE_ECALL_M        = 5'd11;

  localparam trap_cause_t IRQ_CODE_MSI = 5'd3;
  localparam trap_cause_t IRQ_CODE_MTI = 5'd7;
  localparam trap_cause_t IRQ_CODE_MEI = 5'd11;
  localparam int          IRQ_CODE_LOCAL_BASE = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CSR_WR   = 2'd1,
    REDIRECT = 2'd2
  } trap_state_e;

  typedef enum logic [1:0] {
    TVAL_ZERO   = 2'd0,
    TVAL_PC     = 2'd1,
    TVAL_INST   = 2'd2,
    TVAL_LSADDR = 2'd3
  } tval_sel_e;

endpackage
`default_nettype wire

// File: rtl/trap_controller_prio_enc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trap_prio_enc                                                     |
// | Picks the winning trap: interrupts over exceptions, fixed order.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module trap_prio_enc
  import cotm32_priv_pkg::*;
#(
  parameter int NUM_LOCAL_IRQ = 4
) (
  input  logic [EXC_W-1:0]           i_exc,
  // {local[N-1:0], mei, mti, msi}, already masked by the enables
  input  logic [NUM_LOCAL_IRQ+2:0]   i_irq_pend,
  output logic                       o_req,
  output logic                       o_is_irq,
  output trap_cause_t                o_code,
  output tval_sel_e                  o_tval_sel
);

  // Lowest priority assigned first so that higher ones overwrite it
  always_comb begin
    o_req      = 1'b0;
    o_is_irq   = 1'b0;
    o_code     = '0;
    o_tval_sel = TVAL_ZERO;

    if (i_exc[EXC_STORE_MISALIGN]) begin o_code = CAUSE_STORE_MISALIGN; o_tval_sel = TVAL_LSADDR; end
    if (i_exc[EXC_LOAD_MISALIGN])  begin o_code = CAUSE_LOAD_MISALIGN;  o_tval_sel = TVAL_LSADDR; end
    if (i_exc[EXC_STORE_ACCESS])   begin o_code = CAUSE_STORE_ACCESS;   o_tval_sel = TVAL_LSADDR; end
    if (i_exc[EXC_LOAD_ACCESS])    begin o_code = CAUSE_LOAD_ACCESS;    o_tval_sel = TVAL_LSADDR; end
    if (i_exc[EXC_EBREAK])         begin o_code = CAUSE_BREAKPOINT;     o_tval_sel = TVAL_ZERO;   end
    if (i_exc[EXC_ECALL_M])        begin o_code = CAUSE_ECALL_M;        o_tval_sel = TVAL_ZERO;   end
    if (i_exc[EXC_INST_MISALIGN])  begin o_code = CAUSE_INST_MISALIGN;  o_tval_sel = TVAL_PC;     end
    if (i_exc[EXC_ILLEGAL])        begin o_code = CAUSE_ILLEGAL;        o_tval_sel = TVAL_INST;   end
    if (i_exc[EXC_INST_ACCESS])    begin o_code = CAUSE_INST_ACCESS;    o_tval_sel = TVAL_PC;     end

    for (int k = NUM_LOCAL_IRQ - 1; k >= 0; k--) begin
      if (i_irq_pend[3+k]) begin
        o_is_irq   = 1'b1;
        o_code     = trap_cause_t'(IRQ_CODE_LOCAL_BASE + k);
        o_tval_sel = TVAL_ZERO;
      end
    end
    if (i_irq_pend[1]) begin o_is_irq = 1'b1; o_code = IRQ_CODE_MTI; o_tval_sel = TVAL_ZERO; end
    if (i_irq_pend[0]) begin o_is_irq = 1'b1; o_code = IRQ_CODE_MSI; o_tval_sel = TVAL_ZERO; end
    if (i_irq_pend[2]) begin o_is_irq = 1'b1; o_code = IRQ_CODE_MEI; o_tval_sel = TVAL_ZERO; end

    o_req = (|i_exc) | o_is_irq;
  end

endmodule
`default_nettype wire

// File: rtl/trap_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trap_controller                                                   |
// | Commit-stage M-mode trap/MRET sequencer with CSR update+redirect. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module trap_controller
  import cotm32_priv_pkg::*;
#(
  parameter int NUM_LOCAL_IRQ = 4,
  parameter bit VECTORED_EN   = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_commit_valid,
  input  logic [XLEN-1:0]          i_pc,
  input  logic [XLEN-1:0]          i_inst,
  input  logic [XLEN-1:0]          i_ls_addr,
  input  logic [EXC_W-1:0]         i_exc,
  input  logic                     i_mret,
  input  logic                     i_irq_msi,
  input  logic                     i_irq_mti,
  input  logic                     i_irq_mei,
  input  logic [NUM_LOCAL_IRQ-1:0] i_irq_local,
  input  logic                     i_mstatus_mie,
  input  logic [MXLEN-1:0]         i_mie,
  input  logic [MXLEN-1:0]         i_mtvec,
  input  logic [MXLEN-1:0]         i_mepc,
  output logic                     o_busy,
  output logic                     o_flush,
  output logic                     o_csr_trap_we,
  output logic                     o_csr_mret_we,
  output logic [MXLEN-1:0]         o_csr_mcause,
  output logic [MXLEN-1:0]         o_csr_mepc,
  output logic [MXLEN-1:0]         o_csr_mtval,
  output logic [MXLEN-1:0]         o_mip,
  output logic                     o_redirect_valid,
  output logic [XLEN-1:0]          o_redirect_pc,
  input  logic                     i_redirect_ready
);

  localparam int IRQ_N = NUM_LOCAL_IRQ + 3;

  trap_state_e             r_state;
  trap_state_e             w_state_nxt;
  logic [IRQ_N-1:0]        r_irq_pend;
  logic                    r_is_irq;
  trap_cause_t             r_code;
  logic [XLEN-1:0]         r_mepc;
  logic [XLEN-1:0]         r_mtval;
  logic [XLEN-1:0]         r_redirect_pc;

  logic [IRQ_N-1:0]        w_irq_raw;
  logic [IRQ_N-1:0]        w_irq_en;
  logic [IRQ_N-1:0]        w_irq_take;
  logic                    w_req;
  logic                    w_is_irq;
  trap_cause_t             w_code;
  tval_sel_e               w_tval_sel;
  logic [XLEN-1:0]         w_tval;
  logic                    w_take_trap;
  logic                    w_take_mret;
  logic [XLEN-1:0]         w_base;
  logic                    w_vectored;
  logic [XLEN-1:0]         w_trap_pc;
  logic                    w_unused_mie;

  // Compact pending vector: {local[N-1:0], mei, mti, msi}
  assign w_irq_raw = {i_irq_local, i_irq_mei, i_irq_mti, i_irq_msi};
  assign w_irq_en  = {i_mie[IRQ_CODE_LOCAL_BASE +: NUM_LOCAL_IRQ],
                      i_mie[IRQ_CODE_MEI], i_mie[IRQ_CODE_MTI], i_mie[IRQ_CODE_MSI]};
  assign w_irq_take   = r_irq_pend & w_irq_en & {IRQ_N{i_mstatus_mie}};
  assign w_unused_mie = ^i_mie;

  always_comb begin
    o_mip               = '0;
    o_mip[IRQ_CODE_MSI] = r_irq_pend[0];
    o_mip[IRQ_CODE_MTI] = r_irq_pend[1];
    o_mip[IRQ_CODE_MEI] = r_irq_pend[2];
    for (int k = 0; k < NUM_LOCAL_IRQ; k++) begin
      o_mip[IRQ_CODE_LOCAL_BASE+k] = r_irq_pend[3+k];
    end
  end

  trap_prio_enc #(
    .NUM_LOCAL_IRQ (NUM_LOCAL_IRQ)
  ) u_prio_enc (
    .i_exc      (i_exc),
    .i_irq_pend (w_irq_take),
    .o_req      (w_req),
    .o_is_irq   (w_is_irq),
    .o_code     (w_code),
    .o_tval_sel (w_tval_sel)
  );

  always_comb begin
    w_tval = '0;
    case (w_tval_sel)
      TVAL_PC:     w_tval = i_pc;
      TVAL_INST:   w_tval = i_inst;
      TVAL_LSADDR: w_tval = i_ls_addr;
      default:     w_tval = '0;
    endcase
  end

  assign w_base     = {i_mtvec[MXLEN-1:2], 2'b00};
  assign w_vectored = VECTORED_EN && (i_mtvec[1:0] == 2'b01) && r_is_irq;
  assign w_trap_pc  = w_vectored ? (w_base + {{(XLEN-CAUSE_W-2){1'b0}}, r_code, 2'b00}) : w_base;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_take_trap      = 1'b0;
    w_take_mret      = 1'b0;
    o_flush          = 1'b0;
    o_csr_trap_we    = 1'b0;
    o_csr_mret_we    = 1'b0;
    o_redirect_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_commit_valid) begin
          if (w_req) begin
            w_take_trap = 1'b1;
            o_flush     = 1'b1;
            w_state_nxt = CSR_WR;
          end else if (i_mret) begin
            w_take_mret   = 1'b1;
            o_csr_mret_we = 1'b1;
            o_flush       = 1'b1;
            w_state_nxt   = REDIRECT;
          end
        end
      end
      CSR_WR: begin
        o_csr_trap_we = 1'b1;
        o_flush       = 1'b1;
        w_state_nxt   = REDIRECT;
      end
      REDIRECT: begin
        o_redirect_valid = 1'b1;
        o_flush          = 1'b1;
        if (i_redirect_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_irq_pend    <= '0;
      r_is_irq      <= 1'b0;
      r_code        <= '0;
      r_mepc        <= '0;
      r_mtval       <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_irq_pend <= w_irq_raw;
      if (w_take_trap) begin
        r_is_irq <= w_is_irq;
        r_code   <= w_code;
        r_mepc   <= i_pc;
        r_mtval  <= w_tval;
      end
      if (w_take_mret) begin
        r_redirect_pc <= i_mepc;
      end else if (r_state == CSR_WR) begin
        r_redirect_pc <= w_trap_pc;
      end
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign o_csr_mcause  = {r_is_irq, {(MXLEN-1-CAUSE_W){1'b0}}, r_code};
  assign o_csr_mepc    = r_mepc;
  assign o_csr_mtval   = r_mtval;
  assign o_redirect_pc = r_redirect_pc;

endmodule
`default_nettype wire
